// File: rtl/nand_unit_arbiter_if.sv
// rtl/nand_unit_arbiter_if.sv - request/result bundle between requesters and the shared NAND logic unit
interface nand_unit_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] a_bus;
  logic [4*WIDTH-1:0] b_bus;
  logic [7:0]         op_bus;
  logic [3:0]         gnt;
  logic [WIDTH-1:0]   y;
  logic               y_valid;
  logic [1:0]         y_id;
  logic               busy;

  modport master (
    output req, a_bus, b_bus, op_bus,
    input  gnt, y, y_valid, y_id, busy
  );

  modport slave (
    input  req, a_bus, b_bus, op_bus,
    output gnt, y, y_valid, y_id, busy
  );
endinterface

// File: rtl/nand_unit_arbiter.sv
// rtl/nand_unit_arbiter.sv - round-robin arbiter sharing one registered NAND-built logic unit among four requesters
// One operation per three cycles: grant/capture, compute, drain.
module nand_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  nand_unit_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  logic [1:0]       last;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [3:0]       gnt_q;
  logic [WIDTH-1:0] y_q;
  logic             y_valid_q;
  logic [1:0]       y_id_q;
  logic             busy_q;

  logic [1:0]       winner;
  logic             found;
  logic [1:0]       idx;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] result;

  function automatic logic [WIDTH-1:0] nand2(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
    return ~(x & z);
  endfunction

  // Scan from last+1 upward; the fourth step lands back on last itself.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = 2'b00;
    case (winner)
      2'd0: begin a_sel = bus.a_bus[0*WIDTH +: WIDTH]; b_sel = bus.b_bus[0*WIDTH +: WIDTH]; op_sel = bus.op_bus[1:0]; end
      2'd1: begin a_sel = bus.a_bus[1*WIDTH +: WIDTH]; b_sel = bus.b_bus[1*WIDTH +: WIDTH]; op_sel = bus.op_bus[3:2]; end
      2'd2: begin a_sel = bus.a_bus[2*WIDTH +: WIDTH]; b_sel = bus.b_bus[2*WIDTH +: WIDTH]; op_sel = bus.op_bus[5:4]; end
      default: begin a_sel = bus.a_bus[3*WIDTH +: WIDTH]; b_sel = bus.b_bus[3*WIDTH +: WIDTH]; op_sel = bus.op_bus[7:6]; end
    endcase
  end

  // Every opcode is expressed purely in terms of the NAND primitive.
  always_comb begin
    result = nand2(a_q, b_q);
    case (op_q)
      2'b00:   result = nand2(a_q, b_q);
      2'b01:   result = nand2(nand2(a_q, b_q), nand2(a_q, b_q));
      2'b10:   result = nand2(nand2(a_q, a_q), nand2(b_q, b_q));
      default: result = nand2(a_q, a_q);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 2'd3;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 2'b00;
      gnt_q     <= 4'b0000;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_id_q    <= 2'd0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_q    <= a_sel;
            b_q    <= b_sel;
            op_q   <= op_sel;
            gnt_q  <= 4'b0001 << winner;
            last   <= winner;
            y_id_q <= winner;
            busy_q <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          gnt_q     <= 4'b0000;
          y_q       <= result;
          y_valid_q <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          y_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          gnt_q     <= 4'b0000;
          y_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_id    = y_id_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_nand_unit_arbiter.sv
// tb/tb_nand_unit_arbiter.sv - directed bench for nand_unit_arbiter at WIDTH 8
module tb_nand_unit_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  nand_unit_arbiter_if #(.WIDTH(8)) bus ();

  nand_unit_arbiter #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.gnt == 4'b0000 && waited < 8);
    chk("gnt_seen", 32'(bus.gnt != 4'b0000), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_y"}, 32'(bus.y), 32'd0);
    chk({tag, "_y_valid"}, 32'(bus.y_valid), 32'd0);
    chk({tag, "_y_id"}, 32'(bus.y_id), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic [7:0] exp_y, input string tag);
    int w;
    bus.req = 4'b0000;
    bus.req[id] = 1'b1;
    bus.a_bus[id*8 +: 8] = a;
    bus.b_bus[id*8 +: 8] = b;
    bus.op_bus[id*2 +: 2] = op;
    wait_gnt(w);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(4'b0001 << id));
    chk({tag, "_y_id_at_gnt"}, 32'(bus.y_id), 32'(id));
    // Operands change right after the grant edge; the result must not follow them.
    bus.req    = 4'b0000;
    bus.a_bus  = ~bus.a_bus;
    bus.b_bus  = ~bus.b_bus;
    bus.op_bus = ~bus.op_bus;
    @(negedge clk);
    chk({tag, "_y_valid"}, 32'(bus.y_valid), 32'd1);
    chk({tag, "_y"}, 32'(bus.y), 32'(exp_y));
    chk({tag, "_y_id"}, 32'(bus.y_id), 32'(id));
    chk({tag, "_gnt_low"}, 32'(bus.gnt), 32'd0);
    @(negedge clk);
    chk({tag, "_y_valid_fall"}, 32'(bus.y_valid), 32'd0);
    chk({tag, "_y_hold"}, 32'(bus.y), 32'(exp_y));
  endtask

  initial begin
    int w;
    checks   = 0;
    failures = 0;
    rst         = 1'b1;
    bus.req     = 4'b1111;
    bus.a_bus   = '0;
    bus.b_bus   = '0;
    bus.op_bus  = '0;

    // Reset held from time zero with all requesters active.
    repeat (2) @(negedge clk);
    chk_zero("reset");

    // Fairness: REQ stays 1111, NAND of zeros gives FF each time.
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(w);
      chk("rr_spacing", 32'(w), 32'd1);
      chk("rr_gnt", 32'(bus.gnt), 32'(4'b0001 << (k % 4)));
      chk("rr_busy_exec", 32'(bus.busy), 32'd1);
      chk("rr_no_valid_with_gnt", 32'(bus.y_valid), 32'd0);
      @(negedge clk);
      chk("rr_y_valid", 32'(bus.y_valid), 32'd1);
      chk("rr_y_id", 32'(bus.y_id), 32'(k % 4));
      chk("rr_y", 32'(bus.y), 32'h0000_00FF);
      chk("rr_gnt_low", 32'(bus.gnt), 32'd0);
      chk("rr_busy_done", 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk("rr_y_valid_fall", 32'(bus.y_valid), 32'd0);
      chk("rr_busy_idle", 32'(bus.busy), 32'd0);
    end

    // Next grant goes to requester 2; reset lands while in EXEC.
    wait_gnt(w);
    chk("pre_rst_gnt", 32'(bus.gnt), 32'h4);
    rst = 1'b1;
    #1;
    chk_zero("rst_exec");
    repeat (2) begin
      @(negedge clk);
      chk("rst_exec_no_valid", 32'(bus.y_valid), 32'd0);
      chk("rst_exec_y", 32'(bus.y), 32'd0);
    end
    rst = 1'b0;
    wait_gnt(w);
    chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
    chk("drain_idle", 32'(bus.busy), 32'd0);

    do_op(2, 8'hF0, 8'h3C, 2'b00, 8'hCF, "nand_r2");
    do_op(1, 8'hA5, 8'h0F, 2'b01, 8'h05, "and_r1");
    do_op(1, 8'hA5, 8'h0F, 2'b10, 8'hAF, "or_r1");
    do_op(1, 8'hA5, 8'h0F, 2'b11, 8'h5A, "not_r1");
    do_op(1, 8'hA5, 8'h0F, 2'b00, 8'hFA, "nand_r1");

    // Pointer wrap after requester 3, then the pointer continues past 0.
    do_op(3, 8'h12, 8'h34, 2'b10, 8'h36, "or_r3");
    bus.req = 4'b1001;
    wait_gnt(w);
    chk("wrap_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
    bus.req = 4'b1001;
    wait_gnt(w);
    chk("wrap_next_gnt", 32'(bus.gnt), 32'h8);
    chk("wrap_next_y_id", 32'(bus.y_id), 32'd3);
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
    chk("final_idle_gnt", 32'(bus.gnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
